// File: rtl/tinyyolohw_example_axis_pattern_gen_if.sv
// tinyyolohw_example_axis_pattern_gen_if: AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tstrb/tlast) with master/slave views
interface tinyyolohw_example_axis_pattern_gen_if #(
  parameter int DATA_W = 512
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  modport master (output tvalid, tdata, tkeep, tstrb, tlast, input tready);
  modport slave (input tvalid, tdata, tkeep, tstrb, tlast, output tready);
endinterface

// File: rtl/tinyyolohw_example_axis_pattern_gen.sv
// tinyyolohw_example_axis_pattern_gen: AXIS burst source; ports clk/rst (m_axis_aclk/m_axis_areset), ctrl start/length/seed/busy/done, m_axis master stream
module tinyyolohw_example_axis_pattern_gen #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_LENGTH_WIDTH     = 32
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_areset,
  input  logic                         ctrl_start,
  input  logic [C_LENGTH_WIDTH-1:0]    ctrl_length,
  input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_seed,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  tinyyolohw_example_axis_pattern_gen_if.master m_axis
);
  localparam int AW = C_ADDER_BIT_WIDTH;
  localparam int LW = C_LENGTH_WIDTH;
  localparam int LANES = C_AXIS_TDATA_WIDTH / AW;
  localparam logic [AW-1:0] STEP = AW'(LANES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] base;
  logic [LW-1:0] rem;
  logic [AW-1:0] src;
  logic [C_AXIS_TDATA_WIDTH-1:0] data_n;
  logic hs, last_hs;
  assign hs = m_axis.tvalid & m_axis.tready;
  assign last_hs = hs && rem == LW'(1);
  assign ctrl_busy = state == RUN;
  assign ctrl_done = state == DONE;
  assign m_axis.tlast = rem == LW'(1);
  assign m_axis.tkeep = '1;
  assign m_axis.tstrb = '1;
  always_ff @(posedge m_axis_aclk)
    state <= m_axis_areset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (ctrl_start ? ((ctrl_length == '0) ? DONE : RUN) : IDLE) :
              (state == RUN)  ? (last_hs ? DONE : RUN) : IDLE;
  end
  // The first beat comes straight from the seed; later beats from base, which already points one beat ahead.
  always_comb begin
    src = (state == IDLE) ? ctrl_seed : base;
    data_n = '0;
    for (int j = 0; j < LANES; j++) data_n[j*AW +: AW] = src + AW'(j);
  end
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      base <= '0;
      rem <= '0;
    end else if (state == IDLE && ctrl_start && ctrl_length != '0) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata <= data_n;
      base <= ctrl_seed + STEP;
      rem <= ctrl_length;
    end else if (hs) begin
      rem <= rem - LW'(1);
      if (rem == LW'(1)) m_axis.tvalid <= 1'b0;
      else begin
        m_axis.tdata <= data_n;
        base <= base + STEP;
      end
    end
  end
endmodule

// File: tb/tb_tinyyolohw_example_axis_pattern_gen.sv
// tb_tinyyolohw_example_axis_pattern_gen: scoreboard bench for the AXIS pattern generator
module tb_tinyyolohw_example_axis_pattern_gen;
  logic clk = 0, rst = 1;
  logic ctrl_start = 0;
  logic [31:0] ctrl_length = 0, ctrl_seed = 0;
  logic ctrl_busy, ctrl_done;
  tinyyolohw_example_axis_pattern_gen_if #(.DATA_W(512)) axis();
  tinyyolohw_example_axis_pattern_gen dut (
    .m_axis_aclk(clk), .m_axis_areset(rst), .ctrl_start(ctrl_start), .ctrl_length(ctrl_length),
    .ctrl_seed(ctrl_seed), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .m_axis(axis)
  );
  always #5 clk = ~clk;
  typedef struct { logic [511:0] d; logic l; } beat_t;
  beat_t q[$];
  int compared = 0, mismatched = 0, hs_cnt = 0;
  bit stall = 0;
  logic [511:0] prev_d;
  logic prev_l;
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic push_burst(input logic [31:0] seed, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < 16; j++) b.d[j*32 +: 32] = seed + 32'(k*16 + j);
      b.l = (k == len - 1);
      q.push_back(b);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("stall_valid", axis.tvalid, 1);
        chk("stall_data", axis.tdata, prev_d);
        chk("stall_last", axis.tlast, prev_l);
      end
      if (axis.tvalid && axis.tready) begin
        hs_cnt++;
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          beat_t b;
          b = q.pop_front();
          chk("beat_data", axis.tdata, b.d);
          chk("beat_last", axis.tlast, b.l);
        end
      end
      stall = axis.tvalid && !axis.tready;
      prev_d = axis.tdata;
      prev_l = axis.tlast;
    end
  end
  task automatic run(input logic [31:0] seed, input int len, input bit rnd, input bit inj);
    int cyc;
    push_burst(seed, len);
    ctrl_seed = seed;
    ctrl_length = len;
    ctrl_start = 1;
    if (!rnd) axis.tready = 1;
    @(posedge clk); #1;
    ctrl_start = 0;
    ctrl_length = 77;
    ctrl_seed = 32'hDEAD0000;
    chk("busy_first", ctrl_busy, len != 0);
    chk("valid_first", axis.tvalid, len != 0);
    cyc = 1;
    while (!ctrl_done && cyc < 400) begin
      if (rnd) axis.tready = 1'($urandom_range(0, 1));
      ctrl_start = inj && cyc == 2;
      ctrl_length = (inj && cyc == 2) ? 3 : 77;
      @(posedge clk); #1;
      cyc++;
    end
    ctrl_start = 0;
    chk("done_seen", ctrl_done, 1);
    if (!rnd) chk("latency", cyc, len + 1);
    chk("busy_at_done", ctrl_busy, 0);
    chk("valid_at_done", axis.tvalid, 0);
    chk("beats_left", q.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse", ctrl_done, 0);
  endtask
  initial begin
    axis.tready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", axis.tvalid, 0);
    chk("rst_last", axis.tlast, 0);
    chk("rst_data", axis.tdata, 0);
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("tkeep", axis.tkeep, {64{1'b1}});
    chk("tstrb", axis.tstrb, {64{1'b1}});
    rst = 0;
    @(posedge clk); #1;
    run(32'h0, 4, 0, 0);
    run(32'h0, 8, 1, 0);
    run(32'h0, 0, 0, 0);
    run(32'h40, 5, 0, 1);
    run(32'hFFFFFFF8, 2, 0, 0);
    push_burst(32'h200, 10);
    hs_cnt = 0;
    ctrl_seed = 32'h200;
    ctrl_length = 10;
    ctrl_start = 1;
    axis.tready = 1;
    @(posedge clk); #1;
    ctrl_start = 0;
    repeat (3) @(posedge clk);
    #1;
    axis.tready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("hs_before_reset", hs_cnt, 3);
    chk("stalled_valid", axis.tvalid, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_valid", axis.tvalid, 0);
    chk("mid_rst_last", axis.tlast, 0);
    chk("mid_rst_data", axis.tdata, 0);
    chk("mid_rst_busy", ctrl_busy, 0);
    rst = 0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      chk("no_done_after_rst", ctrl_done, 0);
      @(posedge clk); #1;
    end
    run(32'h1000, 3, 0, 0);
    run(32'd100, 32, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
